// File: rtl/arp_frame_tx.sv
// arp_frame_tx: serialises one Ethernet II ARP frame (preamble/SFD, MAC header, ARP body, pad, FCS) then an IFG.
// Define ARP_TX_VLAN_EN to insert an 802.1Q tag (8100 + i_vlan_tci) ahead of the ethertype.
module arp_frame_tx #(
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_LEN      = 12,
    parameter logic [15:0] ETHERTYPE    = 16'h0806
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_operation,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [47:0] i_sha,
    input  logic [31:0] i_spa,
    input  logic [47:0] i_tha,
    input  logic [31:0] i_tpa,
    input  logic [15:0] i_vlan_tci,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_tx_en,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_busy,
    output logic        o_done
);

`ifdef ARP_TX_VLAN_EN
    localparam int unsigned HDR_LEN = 18;
`else
    localparam int unsigned HDR_LEN = 14;
`endif
    localparam int unsigned HDR_BITS = HDR_LEN * 8;
    localparam int unsigned ARP_LEN  = 28;
    localparam int unsigned PAD_LEN  = (MIN_FRAME > HDR_LEN + ARP_LEN) ? MIN_FRAME - HDR_LEN - ARP_LEN : 0;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_ARP, S_PAD, S_FCS, S_IFG} state_t;

    state_t        r_state, w_next;
    logic [10:0]   r_cnt;
    logic [31:0]   r_crc;
    logic          r_done;
    logic [15:0]   r_oper;
    logic [47:0]   r_dst, r_src, r_sha, r_tha;
    logic [31:0]   r_spa, r_tpa;
    logic          w_cnt_clr, w_cnt_inc, w_done_set, w_latch, w_xfer;
    logic [31:0]   w_fcs;
    logic [HDR_BITS-1:0]  w_hdr_vec;
    logic [ARP_LEN*8-1:0] w_arp_vec;

`ifdef ARP_TX_VLAN_EN
    logic [15:0]   r_tci;
    assign w_hdr_vec = {r_dst, r_src, 16'h8100, r_tci, ETHERTYPE};
`else
    logic          w_unused_tci;
    assign w_unused_tci = ^i_vlan_tci;
    assign w_hdr_vec = {r_dst, r_src, ETHERTYPE};
`endif
    assign w_arp_vec = {16'h0001, 16'h0800, 8'h06, 8'h04, r_oper, r_sha, r_spa, r_tha, r_tpa};
    assign w_fcs     = ~r_crc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    always_comb begin
        w_next     = r_state;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_done_set = 1'b0;
        w_latch    = 1'b0;
        o_tx_en    = (r_state inside {S_PRE, S_HDR, S_ARP, S_PAD, S_FCS});
        o_sof      = (r_state == S_PRE) && (r_cnt == '0);
        o_eof      = (r_state == S_FCS) && (r_cnt == 11'd3);
        o_busy     = (r_state != S_IDLE);
        o_done     = r_done;
        o_data     = '0;
        w_xfer     = o_tx_en && i_ready;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_next    = S_PRE;
                w_cnt_clr = 1'b1;
                w_latch   = 1'b1;
            end
            S_PRE: begin
                o_data = (r_cnt == 11'(PREAMBLE_LEN - 1)) ? 8'hD5 : 8'h55;
                if (w_xfer) begin
                    if (r_cnt == 11'(PREAMBLE_LEN - 1)) begin
                        w_next    = S_HDR;
                        w_cnt_clr = 1'b1;
                    end else w_cnt_inc = 1'b1;
                end
            end
            S_HDR: begin
                for (int unsigned i = 0; i < HDR_LEN; i++)
                    if (r_cnt == 11'(i)) o_data = w_hdr_vec[8*(HDR_LEN-1-i) +: 8];
                if (w_xfer) begin
                    if (r_cnt == 11'(HDR_LEN - 1)) begin
                        w_next    = S_ARP;
                        w_cnt_clr = 1'b1;
                    end else w_cnt_inc = 1'b1;
                end
            end
            S_ARP: begin
                for (int unsigned i = 0; i < ARP_LEN; i++)
                    if (r_cnt == 11'(i)) o_data = w_arp_vec[8*(ARP_LEN-1-i) +: 8];
                if (w_xfer) begin
                    if (r_cnt == 11'(ARP_LEN - 1)) begin
                        w_next    = (PAD_LEN != 0) ? S_PAD : S_FCS;
                        w_cnt_clr = 1'b1;
                    end else w_cnt_inc = 1'b1;
                end
            end
            S_PAD: if (w_xfer) begin
                if (r_cnt == 11'(PAD_LEN - 1)) begin
                    w_next    = S_FCS;
                    w_cnt_clr = 1'b1;
                end else w_cnt_inc = 1'b1;
            end
            S_FCS: begin
                o_data = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                // IFG state covers IFG_LEN-1 cycles; the IDLE cycle carrying o_done is the last gap cycle.
                // IFG_LEN of 0 or 1 both place o_done one cycle after eof.
                if (w_xfer) begin
                    if (r_cnt == 11'd3) begin
                        w_cnt_clr = 1'b1;
                        if (IFG_LEN > 1) w_next = S_IFG;
                        else begin
                            w_next     = S_IDLE;
                            w_done_set = 1'b1;
                        end
                    end else w_cnt_inc = 1'b1;
                end
            end
            S_IFG: begin
                if (r_cnt == 11'(IFG_LEN - 2)) begin
                    w_next     = S_IDLE;
                    w_done_set = 1'b1;
                    w_cnt_clr  = 1'b1;
                end else w_cnt_inc = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_crc   <= '1;
            r_done  <= 1'b0;
            r_oper  <= '0;
            r_dst   <= '0;
            r_src   <= '0;
            r_sha   <= '0;
            r_spa   <= '0;
            r_tha   <= '0;
            r_tpa   <= '0;
`ifdef ARP_TX_VLAN_EN
            r_tci   <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 11'd1;
            if (r_state == S_IDLE || r_state == S_PRE) r_crc <= '1;
            else if (w_xfer && r_state != S_FCS)       r_crc <= crc32_byte(r_crc, o_data);
            if (w_latch) begin
                r_oper <= i_operation;
                r_dst  <= i_dst_mac;
                r_src  <= i_src_mac;
                r_sha  <= i_sha;
                r_spa  <= i_spa;
                r_tha  <= i_tha;
                r_tpa  <= i_tpa;
`ifdef ARP_TX_VLAN_EN
                r_tci  <= i_vlan_tci;
`endif
            end
        end
    end

endmodule
